// File: rtl/eth_pcs_pkg.sv
// eth_pcs_pkg: shared 64B/66B PCS constants and block serialisation helper
package eth_pcs_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;
    localparam int BLOCK_W  = 66;
    localparam int WORD_W   = 64;
    localparam int GB_BUF_W = 130;

    typedef enum logic [1:0] {
        SYNC_T_DATA = SYNC_DATA,
        SYNC_T_CTRL = SYNC_CTRL
    } sync_t;

    // Serial bit order: sync[0], sync[1], then payload bit 0 upward; bit 0 goes first.
    function automatic logic [BLOCK_W-1:0] block_to_serial(input logic [BLOCK_W-1:0] blk);
        return {blk[63:0], blk[65], blk[64]};
    endfunction

endpackage

// File: rtl/tx_gearbox.sv
// tx_gearbox: 66-bit block to 64-bit word TX gearbox (32 blocks -> 33 words)
module tx_gearbox
    import eth_pcs_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = BLOCK_W,
    parameter int DATA_OUT_WIDTH = WORD_W,
    parameter int BUF_WIDTH      = GB_BUF_W
) (
    input  logic                      tx_clk,
    input  logic                      tx_rst,
    input  logic [DATA_IN_WIDTH-1:0]  data_in,
    input  logic                      data_valid_in,
    output logic                      data_ready_out,
    output logic [DATA_OUT_WIDTH-1:0] data_out,
    output logic                      data_valid_out,
    input  logic                      data_ready_in,
    output logic [7:0]                fill_level
);

    logic [BUF_WIDTH-1:0] bits_q, bits_d, ins;
    logic [7:0]           count_q, count_d, base;
    logic                 out_fire, in_fire;

    assign data_valid_out = count_q >= 8'd64;
    assign data_out       = bits_q[DATA_OUT_WIDTH-1:0];
    assign fill_level     = count_q;

    // Drop the outgoing word first, then insert the new block right above the surviving bits.
    always_comb begin
        out_fire       = data_valid_out && data_ready_in;
        base           = out_fire ? count_q - 8'd64 : count_q;
        data_ready_out = base <= 8'd64;
        in_fire        = data_valid_in && data_ready_out;
        ins            = {{(BUF_WIDTH-DATA_IN_WIDTH){1'b0}}, block_to_serial(data_in)} << base;
        bits_d         = (out_fire ? bits_q >> DATA_OUT_WIDTH : bits_q) | (in_fire ? ins : '0);
        count_d        = in_fire ? base + 8'd66 : base;
    end

    // Bit buffer and fill count; reset discards any partial word.
    always_ff @(posedge tx_clk or negedge tx_rst) begin
        if (!tx_rst) begin
            bits_q  <= '0;
            count_q <= '0;
        end else begin
            bits_q  <= bits_d;
            count_q <= count_d;
        end
    end

endmodule
